adc_seq_ctrl: RTL and testbench

- Sequencer between a software/timer request source and an external parallel ADC with the pins TRIGGER, RESET, DATA, DVALID and BUSY (the adc_mock contract).
- Issues single-cycle trigger pulses on request or on a programmable period, waits for DVALID with timeout, captures DATA into a first-word-fall-through (FWFT) FIFO, and pulses ADC RESET on power-up and error recovery.
- Sits on the GPIO_0 ADC pinout, between the SoC peripheral bus and the converter.

---
 rtl/adc_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: request/period driven trigger sequencer for a parallel ADC.
// Issues one-cycle trigger pulses, waits for DVALID with a timeout, pushes
// samples into a first-word-fall-through FIFO and pulses the ADC reset on
// power-up and after a timeout.
module adc_seq_ctrl #(
    parameter int WORD_SIZE      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RESET_PULSE    = 4,
    parameter int PERIOD_W       = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic                        CONT_EN,
    input  logic [PERIOD_W-1:0]         PERIOD,
    input  logic                        ERR_CLR,
    output logic                        ADC_TRIGGER,
    output logic                        ADC_RESET,
    input  logic [WORD_SIZE-1:0]        ADC_DATA,
    input  logic                        ADC_DVALID,
    input  logic                        ADC_BUSY,
    input  logic                        RD_EN,
    output logic [WORD_SIZE-1:0]        RD_DATA,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
    output logic                        FIFO_EMPTY,
    output logic                        FIFO_FULL,
    output logic                        OVERRUN,
    output logic                        TIMEOUT_ERR,
    output logic                        IRQ,
    output logic [2:0]                  STATE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RESET_PULSE) + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_PULSE - 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_TRIG    = 3'd2,
        S_WAIT    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [RW-1:0]        rst_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [PERIOD_W-1:0]  per_cnt, per_last;
    logic                 tick, pending;
    logic                 take_req, capture, timeout_hit;

    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]        count, count_n;
    logic                 pop, push, drop;
    logic [WORD_SIZE-1:0] head_n;

    // A PERIOD of 0 behaves like 1; >= keeps ticking if PERIOD shrinks mid-count.
    assign per_last = (PERIOD == '0) ? '0 : PERIOD - PERIOD_W'(1);
    assign tick     = CONT_EN && (per_cnt >= per_last);

    // State register.
    // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_INIT;
        else       state <= state_n;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            S_INIT, S_RECOVER: if (rst_cnt == RST_LAST) state_n = S_IDLE;
            S_IDLE:            if (pending && !ADC_BUSY) state_n = S_TRIG;
            S_TRIG:            state_n = S_WAIT;
            S_WAIT: begin
                if (ADC_DVALID)               state_n = S_IDLE;
                else if (tmo_cnt == TMO_LAST) state_n = S_RECOVER;
            end
            default:           state_n = S_INIT;
        endcase
    end

    // Moore outputs and per-state strobes; trigger drops with RESET since it decodes state.
    always_comb begin
        ADC_TRIGGER = (state == S_TRIG);
        ADC_RESET   = (state == S_INIT) || (state == S_RECOVER);
        STATE       = state;
        take_req    = (state == S_IDLE) && pending && !ADC_BUSY;
        capture     = (state == S_WAIT) && ADC_DVALID;
        timeout_hit = (state == S_WAIT) && !ADC_DVALID && (tmo_cnt == TMO_LAST);
    end

    // Reset-pulse and timeout counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rst_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (((state == S_INIT) || (state == S_RECOVER)) && (state_n == state))
                rst_cnt <= rst_cnt + RW'(1);
            else
                rst_cnt <= '0;
            if (state == S_TRIG)
                tmo_cnt <= '0;
            else if ((state == S_WAIT) && (tmo_cnt != TMO_LAST))
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Period counter and collapsed request flag; a new request beats the clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            per_cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (!CONT_EN || tick) per_cnt <= '0;
            else                  per_cnt <= per_cnt + PERIOD_W'(1);
            pending <= (pending && !take_req) || START || tick;
        end
    end

    // FIFO push/pop decisions and the head value visible after this edge.
    always_comb begin
        pop      = RD_EN && (count != '0);
        push     = capture && ((count != DEPTH) || pop);
        drop     = capture && (count == DEPTH) && !pop;
        rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_n  = count;
        if (push && !pop)      count_n = count + CW'(1);
        else if (pop && !push) count_n = count - CW'(1);
        if (count_n == '0)                       head_n = '0;
        else if (push && (wr_ptr == rd_ptr_n))   head_n = ADC_DATA;
        else                                     head_n = mem[rd_ptr_n];
    end

    // Sample storage.
    // NOTE: storage is not reset; pointers and count define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= ADC_DATA;
    end

    // FIFO pointers, occupancy and registered head.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            RD_DATA <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            RD_DATA <= head_n;
        end
    end

    assign FIFO_COUNT = count;
    assign FIFO_EMPTY = (count == '0);
    assign FIFO_FULL  = (count == DEPTH);

    // Sticky error flags (set beats clear) and the interrupt pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            IRQ         <= 1'b0;
        end else begin
            if (drop)         OVERRUN <= 1'b1;
            else if (ERR_CLR) OVERRUN <= 1'b0;
            if (timeout_hit)  TIMEOUT_ERR <= 1'b1;
            else if (ERR_CLR) TIMEOUT_ERR <= 1'b0;
            IRQ <= push || timeout_hit;
        end
    end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed sequence with randomized ADC latency and data,
// an ADC mock, and a queue-based FIFO/flag reference model.
module tb_adc_seq_ctrl;

    localparam int WS  = 8;
    localparam int DEP = 4;
    localparam int TMO = 64;
    localparam int RP  = 4;
    localparam int PW  = 16;

    logic          clk, rst, start, cont_en, err_clr, rd_en, dvalid, busy;
    logic [PW-1:0] period;
    logic [WS-1:0] adc_data;
    logic          trig, adc_rst, empty, full, overrun, tmo_err, irq;
    logic [WS-1:0] rd_data;
    logic [2:0]    fifo_count;
    logic [2:0]    state;

    adc_seq_ctrl #(.WORD_SIZE(WS), .FIFO_DEPTH(DEP), .TIMEOUT_CYCLES(TMO),
                   .RESET_PULSE(RP), .PERIOD_W(PW)) dut (
        .CLK(clk), .RESET(rst), .START(start), .CONT_EN(cont_en), .PERIOD(period),
        .ERR_CLR(err_clr), .ADC_TRIGGER(trig), .ADC_RESET(adc_rst), .ADC_DATA(adc_data),
        .ADC_DVALID(dvalid), .ADC_BUSY(busy), .RD_EN(rd_en), .RD_DATA(rd_data),
        .FIFO_COUNT(fifo_count), .FIFO_EMPTY(empty), .FIFO_FULL(full),
        .OVERRUN(overrun), .TIMEOUT_ERR(tmo_err), .IRQ(irq), .STATE(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model and ADC mock state
    logic [WS-1:0] q[$];
    bit  ovr_m, tmo_m, irq_m;
    int  cyc, trig_count, irq_count, tmo_due;
    int  trig_cyc[$];
    bit  mock_on, cap_ok, pop_on_cap, chk_on;
    int  mock_delay, mock_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_trigger"}, trig, 0);
        check({tag, "_adc_reset"}, adc_rst, 1);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, tmo_err, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_state"}, state, 0);
    endtask

    task automatic model_reset();
        q.delete();
        ovr_m = 0; tmo_m = 0; irq_m = 0;
        mock_cnt = 0; dvalid = 0; busy = 0; cap_ok = 0; tmo_due = -1;
    endtask

    // One clock: update model with the inputs of this cycle, step, compare, react.
    task automatic cycle();
        bit pop_ok, cap, push_m, drop_m, tmo_now;
        pop_ok  = rd_en && (q.size() > 0);
        cap     = dvalid && cap_ok;
        push_m  = cap && ((q.size() < DEP) || pop_ok);
        drop_m  = cap && !push_m;
        tmo_now = (cyc + 1 == tmo_due);
        irq_m   = push_m || tmo_now;
        if (drop_m) ovr_m = 1; else if (err_clr) ovr_m = 0;
        if (tmo_now) tmo_m = 1; else if (err_clr) tmo_m = 0;
        if (pop_ok) void'(q.pop_front());
        if (push_m) q.push_back(adc_data);
        @(posedge clk);
        #1;
        cyc++;
        if (irq === 1'b1) irq_count++;
        if (chk_on) begin
            check("fifo_count", fifo_count, q.size());
            if (q.size() != 0) check("rd_data", rd_data, q[0]);
            else               check("rd_data_empty", rd_data, 0);
            check("fifo_empty", empty, q.size() == 0);
            check("fifo_full", full, q.size() == DEP);
            check("overrun", overrun, ovr_m);
            check("timeout_err", tmo_err, tmo_m);
            check("irq", irq, irq_m);
        end
        if (dvalid) begin dvalid = 0; busy = 0; cap_ok = 0; end
        if (mock_cnt > 0) begin
            mock_cnt--;
            if (mock_cnt == 0) begin
                dvalid   = 1;
                adc_data = WS'($urandom);
                cap_ok   = (mock_delay <= TMO);
            end
        end
        if (trig === 1'b1) begin
            trig_count++;
            trig_cyc.push_back(cyc);
            if (mock_on) begin busy = 1; mock_cnt = mock_delay; end
            if (!mock_on || mock_delay > TMO) tmo_due = cyc + TMO + 1;
        end
        if (pop_on_cap) rd_en = dvalid;
    endtask

    task automatic pulse_start();
        start = 1; cycle(); start = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi, t0, t_trig, per, prev;
        rst = 1; start = 0; cont_en = 0; err_clr = 0; rd_en = 0;
        period = '0; adc_data = '0; pop_on_cap = 0; chk_on = 0; mock_on = 1;
        cyc = 0; trig_count = 0; irq_count = 0; mock_delay = 5;
        model_reset();

        // reset values, then ADC reset pulse length after release
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 0; chk_on = 1;
        hi = adc_rst ? 1 : 0;
        repeat (7) begin cycle(); if (adc_rst) hi++; end
        check("init_reset_len", hi, RP);
        check("init_state", state, 1);
        check("init_no_trigger", trig_count, 0);

        // single START conversions and pops
        mock_delay = $urandom_range(1, 8);
        pulse_start();
        repeat (mock_delay + 6) cycle();
        check("start1_trig", trig_count, 1);
        check("start1_count", fifo_count, 1);
        check("start1_irq", irq_count, 1);
        pulse_start();
        repeat (mock_delay + 6) cycle();
        check("start2_trig", trig_count, 2);
        check("start2_count", fifo_count, 2);
        rd_en = 1; cycle(); rd_en = 0;
        check("pop_head", rd_data, (q.size() != 0) ? 32'(q[0]) : 32'hdead);
        rd_en = 1; repeat (3) cycle(); rd_en = 0;   // includes reads on empty
        check("drained", empty, 1);

        // periodic triggering, no reads: fifth sample overruns
        per = $urandom_range(12, 24);
        period = PW'(per);
        mock_delay = $urandom_range(1, 8);
        t0 = trig_count; trig_cyc.delete();
        cont_en = 1;
        repeat (5 * per + 5) cycle();
        cont_en = 0;
        repeat (15) cycle();
        check("cont_triggers", trig_count - t0, 5);
        for (int i = 1; i < trig_cyc.size(); i++)
            check("cont_spacing", trig_cyc[i] - trig_cyc[i-1], per);
        check("cont_full", full, 1);
        check("cont_overrun", overrun, 1);
        err_clr = 1; cycle(); err_clr = 0;
        check("errclr_overrun", overrun, 0);

        // capture into a full FIFO with a same-cycle read
        pop_on_cap = 1;
        mock_delay = $urandom_range(1, 8);
        pulse_start();
        repeat (mock_delay + 6) cycle();
        pop_on_cap = 0; rd_en = 0;
        check("fullpop_count", fifo_count, DEP);
        check("fullpop_overrun", overrun, 0);
        rd_en = 1; repeat (4) cycle(); rd_en = 0;

        // PERIOD=0 behaves as 1: back-to-back conversions
        period = '0;
        mock_delay = $urandom_range(1, 4);
        trig_cyc.delete();
        cont_en = 1;
        repeat (30) cycle();
        cont_en = 0;
        repeat (20) cycle();
        check("period0_triggers", trig_cyc.size() >= 4, 1);
        for (int i = 1; i < 4 && i < trig_cyc.size(); i++)
            check("period0_spacing", trig_cyc[i] - trig_cyc[i-1], mock_delay + 2);
        err_clr = 1; rd_en = 1; cycle(); err_clr = 0;
        repeat (4) cycle(); rd_en = 0;

        // BUSY holds the request pending
        busy = 1;
        pulse_start();
        t0 = trig_count;
        repeat (10) cycle();
        check("busy_hold", trig_count - t0, 0);
        busy = 0;
        repeat (15) cycle();
        check("busy_release", trig_count - t0, 1);
        check("busy_state", state, 1);
        rd_en = 1; cycle(); rd_en = 0;

        // DVALID on the last timeout cycle is captured without error
        prev = q.size();
        mock_delay = TMO;
        pulse_start();
        repeat (75) cycle();
        check("lastcycle_capture", fifo_count, prev + 1);
        check("lastcycle_noerr", tmo_err, 0);

        // timeout: late DVALID arrives after recovery has begun
        mock_delay = TMO + 1;
        t0 = trig_count;
        pulse_start();
        for (int i = 0; i < 10 && trig_count == t0; i++) cycle();
        t_trig = cyc;
        for (int i = 0; i < 100 && tmo_err !== 1'b1; i++) cycle();
        check("timeout_latency", cyc - t_trig, TMO + 1);
        check("timeout_irq", irq, 1);
        check("timeout_state", state, 4);
        hi = adc_rst ? 1 : 0;
        repeat (6) begin cycle(); if (adc_rst) hi++; end
        check("recover_reset_len", hi, RP);
        check("recover_state", state, 1);
        err_clr = 1; cycle(); err_clr = 0;
        check("errclr_timeout", tmo_err, 0);

        // RESET during TRIG drops the trigger immediately
        mock_delay = 5;
        t0 = trig_count;
        pulse_start();
        for (int i = 0; i < 10 && trig_count == t0; i++) cycle();
        check("trig_seen", trig, 1);
        #2 rst = 1;
        #1;
        check_reset("rst_trig");
        chk_on = 0; model_reset();
        repeat (2) cycle();
        rst = 0; chk_on = 1;
        repeat (6) cycle();

        // RESET during WAIT_DATA with samples in the FIFO
        mock_delay = 2;
        pulse_start();
        repeat (8) cycle();
        check("prewait_count", fifo_count, 1);
        mock_delay = 30;
        pulse_start();
        repeat (10) cycle();
        check("in_wait_state", state, 3);
        rst = 1;
        #1;
        check_reset("rst_wait");
        chk_on = 0; model_reset();
        repeat (2) cycle();
        rst = 0; chk_on = 1;
        repeat (6) cycle();
        check("post_reset_state", state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
